mc6809e_bus_ctrl: RTL and testbench
===================================

// Module: mc6809e_bus_ctrl
// PURPOSE
//  Clock and bus sequencer for one mc6809e CPU core.
//  - Derives the quadrature E/Q clocks from the system clock.
//  - Holds the CPU in reset for a set number of E cycles.
//  - Gives an external requester (DMA, sub-CPU, video fetch) exclusive bus ownership.
//    It halts the CPU via nHALT and grants the bus once the CPU reports BA=BS=1.
//  - Sits between the board clock/reset and the CPU wrapper's E, Q, nRESET and nHALT pins.
// PARAMETERS
//  QDIV        2   CLK cycles per E/Q quarter-phase (>=1); E period = 4*QDIV CLK
//  RESET_ECYC  16  E cycles CPU_nRESET is held low after nRESET deasserts (>=1)
// PORTS
//  CLK         in   1  system clock; all logic on rising edge
//  nRESET      in   1  synchronous, active-low reset
//  E           out  1  6809E E clock
//  Q           out  1  6809E Q clock (leads E by 90 deg)
//  E_RISE      out  1  1-CLK pulse, high in the CLK cycle E first reads 1
//  E_FALL      out  1  1-CLK pulse, high in the CLK cycle E first reads 0
//  CPU_nRESET  out  1  reset to CPU, active low
//  nHALT       out  1  halt to CPU, active low
//  BA          in   1  CPU bus available
//  BS          in   1  CPU bus status
//  DMA_REQ     in   1  requester wants the bus; level, held until done
//  DMA_GNT     out  1  requester owns the bus while high
// BEHAVIOUR
//  Reset (nRESET=0 at a CLK edge), applied in the next CLK, whatever the state:
//    sub=0, quarter=0, E=0, Q=0, E_RISE=0, E_FALL=0, CPU_nRESET=0, nHALT=1, DMA_GNT=0,
//    rst_cnt=0, fsm=IDLE. Reset mid-operation aborts any grant at once.
//  Phase generator:
//    - sub counts 0..QDIV-1; quarter advances mod 4 when sub==QDIV-1.
//    - E/Q are registered decodes of quarter: q0 E0Q0, q1 E0Q1, q2 E1Q1, q3 E1Q0.
//    - Order: Q rises, E rises, Q falls, E falls.
//    - E_RISE/E_FALL are registered together with the E edge they mark.
//  Reset stretcher:
//    - rst_cnt (width clog2(RESET_ECYC+1)) counts E_FALL while CPU_nRESET=0.
//    - CPU_nRESET goes high in the same CLK as the RESET_ECYC-th E_FALL pulse.
//    - rst_cnt saturates after that.
//  Arbiter FSM (IDLE, HALT_WAIT, GRANTED, RELEASE):
//    - nHALT changes only in an E_FALL cycle.
//    - BA/BS are sampled only in E_RISE cycles.
//    IDLE: nHALT=1, DMA_GNT=0.
//      E_FALL && DMA_REQ && CPU_nRESET -> HALT_WAIT, nHALT=0 that cycle.
//      DMA_REQ is ignored while CPU_nRESET=0.
//    HALT_WAIT:
//      E_RISE && BA && BS && DMA_REQ -> GRANTED; DMA_GNT=1 on the next CLK.
//      DMA_REQ=0 -> RELEASE, grant never issued.
//      BA and BS are never both high while nHALT=1.
//    GRANTED: DMA_GNT=1.
//      DMA_REQ=0 -> DMA_GNT=0 on the next CLK, -> RELEASE.
//      nHALT stays low until the next E_FALL.
//    RELEASE:
//      nHALT=1 at the first E_FALL.
//      Then E_RISE with BA=0 and nHALT=1 -> IDLE.
//      DMA_REQ is ignored; a new request is accepted from IDLE on a later E_FALL.
//  Simultaneous events:
//    - DMA_REQ rising in the same E_FALL cycle that CPU_nRESET rises is accepted.
//    - DMA_REQ falling in the same cycle as the grant condition -> RELEASE, no grant.
//  Latency: request-to-grant >= 1 E cycle plus the CPU's halt latency.
//    Release-to-IDLE is 1-2 E cycles.
// STRUCTURE
//  - mc6809e_bus_defs.vh: FSM state localparams (IDLE=2'd0, HALT_WAIT=2'd1,
//    GRANTED=2'd2, RELEASE=2'd3) and quarter decode constants.
//  - Sub-module mc6809e_clkgen: sub/quarter counters, E/Q/E_RISE/E_FALL.
//  - The reset stretcher and arbiter FSM live in the top module.
// TESTING (QDIV=2, RESET_ECYC=4; cycle n = nth CLK after nRESET goes high)
//  1 Release reset.
//    -> Q=1 from cycle 2, E=1 from cycle 4 with E_RISE=1 at 4, Q=0 at 6,
//       E=0 with E_FALL=1 at 8; period 8 CLK.
//  2 Reset stretcher: count E_FALL pulses.
//    -> CPU_nRESET=0 through cycle 31, =1 at cycle 32 (4th E_FALL).
//  3 DMA_REQ=1 at cycle 40; model drives BA=BS=1 from cycle 50.
//    -> nHALT=0 at 48, sampled at E_RISE 52, DMA_GNT=1 at 53.
//  4 From GRANTED, DMA_REQ=0 at cycle 60; model drops BA/BS at 66.
//    -> DMA_GNT=0 at 61, nHALT=1 at 64, IDLE after E_RISE 68.
//    -> DMA_REQ=1 at cycle 62 is not honoured until the E_FALL at 72.
//  5 DMA_REQ pulsed high 40..49 with BA=BS held 0.
//    -> nHALT low at 48, high again at 56, DMA_GNT never asserted.
//  6 nRESET=0 for one CLK while GRANTED.
//    -> next CLK: DMA_GNT=0, nHALT=1, CPU_nRESET=0, E=Q=0; test 2 timing repeats.

Source files
------------

// File: rtl/mc6809e_bus_ctrl_pkg.sv
// Shared definitions for the mc6809e bus controller.
//   arb_state_e : bus arbiter states (encodings fixed so a debugger can read them raw)
//   QTR_*       : E/Q quarter-phase indices
//   qtr_decode  : quarter index -> {E, Q} pin levels
package mc6809e_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_HALT_WAIT = 2'd1,
        ARB_GRANTED   = 2'd2,
        ARB_RELEASE   = 2'd3
    } arb_state_e;

    // Quarter sequence: Q rises entering QTR_1, E rises entering QTR_2,
    // Q falls entering QTR_3, E falls entering QTR_0.
    localparam logic [1:0] QTR_0 = 2'd0;
    localparam logic [1:0] QTR_1 = 2'd1;
    localparam logic [1:0] QTR_2 = 2'd2;
    localparam logic [1:0] QTR_3 = 2'd3;

    // Returns {E, Q} for a quarter index.
    function automatic logic [1:0] qtr_decode(input logic [1:0] qtr);
        logic [1:0] eq;
        case (qtr)
            QTR_0:   eq = 2'b00;
            QTR_1:   eq = 2'b01;
            QTR_2:   eq = 2'b11;
            default: eq = 2'b10;
        endcase
        return eq;
    endfunction

endpackage

// File: rtl/mc6809e_clkgen.sv
// Quadrature E/Q clock generator for a 6809E.
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   e_o, q_o       registered E and Q clocks (Q leads E by a quarter period)
//   e_rise_o       1-CLK pulse in the cycle E first reads 1
//   e_fall_o       1-CLK pulse in the cycle E first reads 0
//   e_fall_nxt_o   combinational: e_fall_o will be high after this clock edge
// E period is 4*QDIV system clocks.
module mc6809e_clkgen
    import mc6809e_bus_ctrl_pkg::*;
#(
    parameter int QDIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic e_o,
    output logic q_o,
    output logic e_rise_o,
    output logic e_fall_o,
    output logic e_fall_nxt_o
);

    localparam int SW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [SW-1:0] sub_q, sub_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [1:0]    eq_d;
    logic          advance;
    logic          e_rise_d;
    logic          e_q, q_q, e_rise_q, e_fall_q;

    always_comb begin
        advance      = (sub_q == SW'(QDIV - 1));
        sub_d        = advance ? '0 : sub_q + 1'b1;
        quarter_d    = advance ? quarter_q + 2'd1 : quarter_q;
        eq_d         = qtr_decode(quarter_d);
        // Edge markers are computed from the transition about to happen so
        // they land in the same cycle as the E edge itself.
        e_rise_d     = advance && (quarter_q == QTR_1);
        e_fall_nxt_o = advance && (quarter_q == QTR_3);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sub_q     <= '0;
            quarter_q <= QTR_0;
            e_q       <= 1'b0;
            q_q       <= 1'b0;
            e_rise_q  <= 1'b0;
            e_fall_q  <= 1'b0;
        end else begin
            sub_q     <= sub_d;
            quarter_q <= quarter_d;
            e_q       <= eq_d[1];
            q_q       <= eq_d[0];
            e_rise_q  <= e_rise_d;
            e_fall_q  <= e_fall_nxt_o;
        end
    end

    assign e_o      = e_q;
    assign q_o      = q_q;
    assign e_rise_o = e_rise_q;
    assign e_fall_o = e_fall_q;

endmodule

// File: rtl/mc6809e_bus_ctrl.sv
// Clock, reset and bus-ownership sequencer for one mc6809e CPU core.
//   CLK, nRESET        system clock, synchronous active-low reset
//   E, Q               6809E quadrature clocks
//   E_RISE, E_FALL     1-CLK markers of the E edges
//   CPU_nRESET         CPU reset, held low RESET_ECYC E cycles after nRESET rises
//   nHALT              CPU halt request (changes only in E_FALL cycles)
//   BA, BS             CPU bus-available / bus-status (sampled in E_RISE cycles)
//   DMA_REQ, DMA_GNT   external requester handshake
//
// Requester handshake: DMA_REQ is a level held high for as long as the
// requester wants the bus; DMA_GNT rises only after the CPU has confirmed
// halt (BA=BS=1) and stays high until the CLK after DMA_REQ drops. A
// request that drops before the grant is abandoned without a grant. After
// every request the CPU is un-halted and must drop BA before the next
// request is considered.
module mc6809e_bus_ctrl
    import mc6809e_bus_ctrl_pkg::*;
#(
    parameter int QDIV       = 2,
    parameter int RESET_ECYC = 16
) (
    input  logic CLK,
    input  logic nRESET,
    output logic E,
    output logic Q,
    output logic E_RISE,
    output logic E_FALL,
    output logic CPU_nRESET,
    output logic nHALT,
    input  logic BA,
    input  logic BS,
    input  logic DMA_REQ,
    output logic DMA_GNT
);

    localparam int CW = $clog2(RESET_ECYC + 1);

    logic          e_fall_nxt;
    logic [CW-1:0] rst_cnt_q, rst_cnt_d;
    logic          cpu_nreset_q, cpu_nreset_d;
    arb_state_e    state_q, state_d;
    logic          nhalt_q, nhalt_d;
    logic          gnt_q, gnt_d;

    mc6809e_clkgen #(
        .QDIV (QDIV)
    ) u_clkgen (
        .clk_i        (CLK),
        .rst_ni       (nRESET),
        .e_o          (E),
        .q_o          (Q),
        .e_rise_o     (E_RISE),
        .e_fall_o     (E_FALL),
        .e_fall_nxt_o (e_fall_nxt)
    );

    // Reset stretcher: counts E falling edges while the CPU is in reset.
    // The release is registered alongside the final E_FALL pulse, and the
    // counter freezes once CPU_nRESET is high.
    always_comb begin
        rst_cnt_d    = rst_cnt_q;
        cpu_nreset_d = cpu_nreset_q;
        if (!cpu_nreset_q && e_fall_nxt) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == CW'(RESET_ECYC - 1)) begin
                cpu_nreset_d = 1'b1;
            end
        end
    end

    // Arbiter. nHALT moves only on the edge that also raises E_FALL, so the
    // CPU sees it change with E low. BA/BS are looked at in the cycle that
    // E_RISE is high, i.e. once E has been high for a full CLK.
    always_comb begin
        state_d = state_q;
        nhalt_d = nhalt_q;
        gnt_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // cpu_nreset_d lets a request coincide with the reset release.
                if (e_fall_nxt && DMA_REQ && cpu_nreset_d) begin
                    state_d = ARB_HALT_WAIT;
                    nhalt_d = 1'b0;
                end
            end
            ARB_HALT_WAIT: begin
                if (!DMA_REQ) begin
                    state_d = ARB_RELEASE;
                end else if (E_RISE && BA && BS) begin
                    state_d = ARB_GRANTED;
                    gnt_d   = 1'b1;
                end
            end
            ARB_GRANTED: begin
                if (!DMA_REQ) begin
                    state_d = ARB_RELEASE;
                end else begin
                    gnt_d = 1'b1;
                end
            end
            ARB_RELEASE: begin
                if (e_fall_nxt) begin
                    nhalt_d = 1'b1;
                end
                if (E_RISE && !BA && nhalt_q) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                nhalt_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            rst_cnt_q    <= '0;
            cpu_nreset_q <= 1'b0;
            state_q      <= ARB_IDLE;
            nhalt_q      <= 1'b1;
            gnt_q        <= 1'b0;
        end else begin
            rst_cnt_q    <= rst_cnt_d;
            cpu_nreset_q <= cpu_nreset_d;
            state_q      <= state_d;
            nhalt_q      <= nhalt_d;
            gnt_q        <= gnt_d;
        end
    end

    assign CPU_nRESET = cpu_nreset_q;
    assign nHALT      = nhalt_q;
    assign DMA_GNT    = gnt_q;

endmodule

// File: tb/tb_mc6809e_bus_ctrl.sv
// Self-checking bench for mc6809e_bus_ctrl (QDIV=2, RESET_ECYC=4).
// Expected output transitions {cycle, signal, new value} are queued by the
// stimulus; a monitor pops one entry for every transition the DUT makes.
// Cycle n is the nth CLK edge after nRESET is sampled high.
module tb_mc6809e_bus_ctrl;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic ba = 1'b0;
    logic bs = 1'b0;
    logic dma_req = 1'b0;
    logic e, q, e_rise, e_fall, cpu_nreset, nhalt, dma_gnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    logic [19:0] exp_q[$];
    logic [6:0]  prev;
    logic [6:0]  cur;
    logic [19:0] got_ev;
    logic [19:0] exp_ev;

    mc6809e_bus_ctrl #(
        .QDIV       (2),
        .RESET_ECYC (4)
    ) dut (
        .CLK        (clk),
        .nRESET     (nreset),
        .E          (e),
        .Q          (q),
        .E_RISE     (e_rise),
        .E_FALL     (e_fall),
        .CPU_nRESET (cpu_nreset),
        .nHALT      (nhalt),
        .BA         (ba),
        .BS         (bs),
        .DMA_REQ    (dma_req),
        .DMA_GNT    (dma_gnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic string sig_name(input logic [2:0] id);
        case (id)
            3'd0: return "E";
            3'd1: return "Q";
            3'd2: return "E_RISE";
            3'd3: return "E_FALL";
            3'd4: return "CPU_nRESET";
            3'd5: return "nHALT";
            default: return "DMA_GNT";
        endcase
    endfunction

    task automatic push_ev(input int c, input int id, input logic v);
        exp_q.push_back({16'(c), 3'(id), v});
    endtask

    // First two E periods after reset release.
    task automatic push_phase();
        push_ev(2, 1, 1);
        push_ev(4, 0, 1);  push_ev(4, 2, 1);
        push_ev(5, 2, 0);
        push_ev(6, 1, 0);
        push_ev(8, 0, 0);  push_ev(8, 3, 1);
        push_ev(9, 3, 0);
        push_ev(10, 1, 1);
        push_ev(12, 0, 1); push_ev(12, 2, 1);
        push_ev(13, 2, 0);
        push_ev(14, 1, 0);
        push_ev(16, 0, 0); push_ev(16, 3, 1);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0b expected=%0b (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc got=%0d expected=%0d", cyc, n);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // E/Q/E_RISE/E_FALL are only tracked over the first two E periods after
    // each reset release; the slow control outputs are tracked always.
    always @(negedge clk) begin
        cur = {dma_gnt, nhalt, cpu_nreset, e_fall, e_rise, q, e};
        if (mon_en) begin
            for (int i = 0; i < 7; i++) begin
                if (cur[i] !== prev[i] && (i >= 4 || (cyc >= 1 && cyc <= 16))) begin
                    got_ev = {16'(cyc), 3'(i), cur[i]};
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_edge got cyc=%0d %s=%0b expected no edge",
                                 cyc, sig_name(3'(i)), cur[i]);
                    end else begin
                        exp_ev = exp_q.pop_front();
                        if (got_ev !== exp_ev) begin
                            failures++;
                            $display("FAIL edge got cyc=%0d %s=%0b expected cyc=%0d %s=%0b",
                                     cyc, sig_name(3'(i)), cur[i],
                                     exp_ev[19:4], sig_name(exp_ev[3:1]), exp_ev[0]);
                        end
                    end
                end
            end
        end
        prev = cur;
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check1("rst_E", e, 1'b0);
        check1("rst_Q", q, 1'b0);
        check1("rst_E_RISE", e_rise, 1'b0);
        check1("rst_E_FALL", e_fall, 1'b0);
        check1("rst_CPU_nRESET", cpu_nreset, 1'b0);
        check1("rst_nHALT", nhalt, 1'b1);
        check1("rst_DMA_GNT", dma_gnt, 1'b0);
        mon_en = 1'b1;

        // Run A: phase, reset stretch, grant, release, late request.
        push_phase();
        push_ev(32, 4, 1);
        push_ev(48, 5, 0);
        push_ev(53, 6, 1);
        push_ev(61, 6, 0);
        push_ev(64, 5, 1);
        push_ev(72, 5, 0);
        push_ev(80, 5, 1);
        nreset = 1'b1;
        wait_cyc(40); dma_req = 1'b1;
        wait_cyc(50); ba = 1'b1; bs = 1'b1;
        wait_cyc(60); dma_req = 1'b0;
        wait_cyc(62); dma_req = 1'b1;
        wait_cyc(66); ba = 1'b0; bs = 1'b0;
        wait_cyc(74); dma_req = 1'b0;
        wait_cyc(90);

        // Run B: request abandoned before any grant.
        push_ev(0, 4, 0);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        push_phase();
        push_ev(32, 4, 1);
        push_ev(48, 5, 0);
        push_ev(56, 5, 1);
        nreset = 1'b1;
        wait_cyc(40); dma_req = 1'b1;
        wait_cyc(50); dma_req = 1'b0;
        wait_cyc(70);

        // Run C: grant, then a one-CLK reset while granted.
        push_ev(0, 4, 0);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        push_phase();
        push_ev(32, 4, 1);
        push_ev(48, 5, 0);
        push_ev(53, 6, 1);
        nreset = 1'b1;
        wait_cyc(40); dma_req = 1'b1;
        wait_cyc(50); ba = 1'b1; bs = 1'b1;
        wait_cyc(58);
        check1("pre_rst_Q", q, 1'b1);
        push_ev(0, 4, 0);
        push_ev(0, 5, 1);
        push_ev(0, 6, 0);
        nreset = 1'b0;
        ba = 1'b0; bs = 1'b0;
        @(negedge clk);
        check1("midrst_E", e, 1'b0);
        check1("midrst_Q", q, 1'b0);
        // DMA_REQ stays high through reset: accepted on the releasing E_FALL.
        push_phase();
        push_ev(32, 4, 1);
        push_ev(32, 5, 0);
        push_ev(37, 6, 1);
        push_ev(41, 6, 0);
        push_ev(48, 5, 1);
        nreset = 1'b1;
        wait_cyc(34); ba = 1'b1; bs = 1'b1;
        wait_cyc(40); dma_req = 1'b0;
        wait_cyc(42); ba = 1'b0; bs = 1'b0;
        wait_cyc(64);

        while (exp_q.size() > 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_edge got none expected cyc=%0d %s=%0b",
                     exp_ev[19:4], sig_name(exp_ev[3:1]), exp_ev[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
